// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: raster timing bundle between the sync generator
// and the vga pixel pipeline.
interface vga_sync_gen_if;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       fetch;
  logic [6:0] fetch_col;
  logic [9:0] fetch_row;
  logic       de;
  logic       hsync_out;
  logic       vsync_out;
  logic       frame_start;
  logic       irq_ack;
  logic       frame_irq;

  modport master (
    output hcount, vcount,
    output fetch, fetch_col, fetch_row,
    output de, hsync_out, vsync_out,
    output frame_start, frame_irq,
    input  irq_ack
  );

  modport slave (
    input  hcount, vcount,
    input  fetch, fetch_col, fetch_row,
    input  de, hsync_out, vsync_out,
    input  frame_start, frame_irq,
    output irq_ack
  );
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster counters, delayed syncs/de, cell fetch strobe.
// Optional VGA_SYNC_FRAME_IRQ_EN adds a sticky end-of-visible-frame flag.
module vga_sync_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int SYNC_POL   = 0,
  parameter int PIPE_DELAY = 2,
  parameter int FETCH_LEAD = 8
) (
  input logic           clk,
  input logic           n_rst,
  vga_sync_gen_if.master bus
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT
                         + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT
                         + V_SYNC + V_BACK;
  localparam int HS_BEG = H_VISIBLE + H_FRONT;
  localparam int HS_END = HS_BEG + H_SYNC;
  localparam int VS_BEG = V_VISIBLE + V_FRONT;
  localparam int VS_END = VS_BEG + V_SYNC;

  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic [9:0]  h_next;
  logic [9:0]  v_next;
  logic        h_wrap;
  logic        v_wrap;
  logic        hs_raw;
  logic        vs_raw;
  logic        de_raw;
  logic [10:0] fx_sum;
  logic [9:0]  fx;
  logic [9:0]  fy;
  logic        fetch_hit;
  logic        fetch_q;
  logic [6:0]  col_q;
  logic [9:0]  row_q;
  logic        fs_q;
  logic [2:0]  pipe [PIPE_DELAY];
  logic        hs_d;
  logic        vs_d;

  // next raster position
  always_comb begin
    h_wrap = hcount == 10'(H_TOTAL - 1);
    v_wrap = vcount == 10'(V_TOTAL - 1);
    h_next = h_wrap ? '0 : hcount + 10'd1;
    v_next = vcount;
    if (h_wrap)
      v_next = v_wrap ? '0 : vcount + 10'd1;
  end

  // undelayed sync and display windows
  always_comb begin
    hs_raw = (hcount >= 10'(HS_BEG))
          && (hcount < 10'(HS_END));
    vs_raw = (vcount >= 10'(VS_BEG))
          && (vcount < 10'(VS_END));
    de_raw = (hcount < 10'(H_VISIBLE))
          && (vcount < 10'(V_VISIBLE));
  end

  // fetch target for the pixel that becomes current next cycle
  always_comb begin
    fx_sum = {1'b0, h_next} + 11'(FETCH_LEAD);
    fx     = 10'(fx_sum);
    fy     = v_next;
    if (fx_sum >= 11'(H_TOTAL)) begin
      fx = 10'(fx_sum - 11'(H_TOTAL));
      fy = (v_next == 10'(V_TOTAL - 1))
         ? '0 : v_next + 10'd1;
    end
    fetch_hit = (fx < 10'(H_VISIBLE))
             && (fx[2:0] == 3'd0)
             && (fy < 10'(V_VISIBLE));
  end

  // free-running counters
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hcount <= '0;
      vcount <= '0;
    end else begin
      hcount <= h_next;
      vcount <= v_next;
    end
  end

  // fetch strobe and held cell address, frame start pulse
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fetch_q <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      fs_q    <= 1'b0;
    end else begin
      fetch_q <= fetch_hit;
      fs_q    <= (h_next == '0) && (v_next == '0);
      if (fetch_hit) begin
        col_q <= fx[9:3];
        row_q <= fy;
      end
    end
  end

  // matched delay line for {vs, hs, de}
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < PIPE_DELAY; i++)
        pipe[i] <= '0;
    end else begin
      pipe[0] <= {vs_raw, hs_raw, de_raw};
      for (int i = 1; i < PIPE_DELAY; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  assign hs_d = pipe[PIPE_DELAY-1][1];
  assign vs_d = pipe[PIPE_DELAY-1][2];

  assign bus.hcount      = hcount;
  assign bus.vcount      = vcount;
  assign bus.fetch       = fetch_q;
  assign bus.fetch_col   = col_q;
  assign bus.fetch_row   = row_q;
  assign bus.frame_start = fs_q;
  assign bus.de          = pipe[PIPE_DELAY-1][0];
  assign bus.hsync_out   = (SYNC_POL != 0) ? hs_d : ~hs_d;
  assign bus.vsync_out   = (SYNC_POL != 0) ? vs_d : ~vs_d;

`ifdef VGA_SYNC_FRAME_IRQ_EN
  logic irq_q;
  logic irq_set;

  assign irq_set = h_wrap
                && (vcount == 10'(V_VISIBLE - 1));

  // sticky flag, a set beats a coincident ack
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      irq_q <= 1'b0;
    else if (irq_set)
      irq_q <= 1'b1;
    else if (bus.irq_ack)
      irq_q <= 1'b0;
  end

  assign bus.frame_irq = irq_q;
`else
  logic irq_ack_unused;

  assign irq_ack_unused = bus.irq_ack;
  assign bus.frame_irq  = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed vectors on a reduced 48x12 raster
// plus counting, irq and mid-frame reset sequences.
module tb_vga_sync_gen;

  localparam int HV = 32;
  localparam int HF = 4;
  localparam int HS = 8;
  localparam int HB = 4;
  localparam int VV = 6;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int SP = 0;
  localparam int PD = 2;
  localparam int FL = 8;
  localparam int HT = 48;
  localparam int VT = 12;
  localparam int FR = HT * VT;
`ifdef VGA_SYNC_FRAME_IRQ_EN
  localparam logic IRQ = 1'b1;
`else
  localparam logic IRQ = 1'b0;
`endif

  typedef struct {
    int   h;
    int   v;
    logic de;
    logic hs;
    logic vs;
    logic fe;
    int   col;
    int   row;
    logic fs;
  } vec_t;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   k = 0;
  vec_t tbl [21];

  vga_sync_gen_if bus ();

  vga_sync_gen #(
    .H_VISIBLE (HV), .H_FRONT (HF),
    .H_SYNC    (HS), .H_BACK  (HB),
    .V_VISIBLE (VV), .V_FRONT (VF),
    .V_SYNC    (VS), .V_BACK  (VB),
    .SYNC_POL  (SP), .PIPE_DELAY (PD),
    .FETCH_LEAD (FL)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic lvl(logic act);
    return (SP != 0) ? act : ~act;
  endfunction

  function automatic logic [41:0] pk(vec_t t);
    return {10'(t.h), 10'(t.v), t.de,
            lvl(t.hs), lvl(t.vs), t.fe,
            7'(t.col), 10'(t.row), t.fs};
  endfunction

  function automatic logic [41:0] obs();
    return {bus.hcount, bus.vcount, bus.de,
            bus.hsync_out, bus.vsync_out,
            bus.fetch, bus.fetch_col,
            bus.fetch_row, bus.frame_start};
  endfunction

  function automatic string fmt(logic [41:0] x);
    return $sformatf(
      "h=%0d v=%0d de=%b hs=%b vs=%b fetch=%b col=%0d row=%0d fs=%b",
      x[41:32], x[31:22], x[21], x[20], x[19],
      x[18], x[17:11], x[10:1], x[0]);
  endfunction

  task automatic chk(string nm, logic [41:0] exp);
    logic [41:0] act;
    act = obs();
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %s want %s",
               nm, fmt(act), fmt(exp));
    end
  endtask

  task automatic chk1(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
    k += n;
  endtask

  task automatic go(int p);
    if (p > k) step(p - k);
  endtask

  task automatic go_hv(int f, int h, int v);
    go(f * FR + v * HT + h);
  endtask

  initial begin
    int de_n, hs_n, vs_n, fe_n, fs_n;
    int pos_err, ord_err, irq_hi;
    int hs_first, vs_first, de_first;
    int h, v, ec, er;
    vec_t t;

    tbl[0]  = '{0,  0,  0, 0, 0, 1, 1, 0, 1};
    tbl[1]  = '{1,  0,  0, 0, 0, 0, 1, 0, 0};
    tbl[2]  = '{2,  0,  1, 0, 0, 0, 1, 0, 0};
    tbl[3]  = '{8,  0,  1, 0, 0, 1, 2, 0, 0};
    tbl[4]  = '{16, 3,  1, 0, 0, 1, 3, 3, 0};
    tbl[5]  = '{33, 3,  1, 0, 0, 0, 3, 3, 0};
    tbl[6]  = '{34, 3,  0, 0, 0, 0, 3, 3, 0};
    tbl[7]  = '{37, 3,  0, 0, 0, 0, 3, 3, 0};
    tbl[8]  = '{38, 3,  0, 1, 0, 0, 3, 3, 0};
    tbl[9]  = '{40, 3,  0, 1, 0, 1, 0, 4, 0};
    tbl[10] = '{41, 3,  0, 1, 0, 0, 0, 4, 0};
    tbl[11] = '{45, 3,  0, 1, 0, 0, 0, 4, 0};
    tbl[12] = '{46, 3,  0, 0, 0, 0, 0, 4, 0};
    tbl[13] = '{40, 5,  0, 1, 0, 0, 3, 5, 0};
    tbl[14] = '{0,  6,  0, 0, 0, 0, 3, 5, 0};
    tbl[15] = '{2,  6,  0, 0, 0, 0, 3, 5, 0};
    tbl[16] = '{1,  8,  0, 0, 0, 0, 3, 5, 0};
    tbl[17] = '{2,  8,  0, 0, 1, 0, 3, 5, 0};
    tbl[18] = '{1,  10, 0, 0, 1, 0, 3, 5, 0};
    tbl[19] = '{2,  10, 0, 0, 0, 0, 3, 5, 0};
    tbl[20] = '{40, 11, 0, 1, 0, 1, 0, 0, 0};

    bus.irq_ack = 1'b0;
    #1000;
    chk("reset", pk('{0, 0, 0, 0, 0, 0, 0, 0, 0}));
    chk1("reset_irq", int'(bus.frame_irq), 0);
    @(negedge clk);
    n_rst = 1'b1;
    k = 0;

    for (int i = 0; i < 21; i++) begin
      go_hv(1, tbl[i].h, tbl[i].v);
      chk($sformatf("vec%0d", i), pk(tbl[i]));
    end

    de_n = 0; hs_n = 0; vs_n = 0;
    fe_n = 0; fs_n = 0; irq_hi = 0;
    pos_err = 0; ord_err = 0;
    hs_first = -1; vs_first = -1; de_first = -1;
    go_hv(2, 0, 0);
    for (int i = 0; i < FR; i++) begin
      h = i % HT;
      v = i / HT;
      if (bus.hcount != 10'(h) || bus.vcount != 10'(v))
        pos_err++;
      if (bus.de) begin
        de_n++;
        if (de_first < 0) de_first = i;
      end
      if (bus.hsync_out == lvl(1'b1)) begin
        hs_n++;
        if (hs_first < 0) hs_first = i;
      end
      if (bus.vsync_out == lvl(1'b1)) begin
        vs_n++;
        if (vs_first < 0) vs_first = i;
      end
      if (bus.frame_start) fs_n++;
      if (bus.frame_irq) irq_hi++;
      if (bus.fetch) begin
        fe_n++;
        ec = (h >= HT - FL) ? 0 : h / 8 + 1;
        er = (h >= HT - FL) ? (v + 1) % VT : v;
        if (bus.fetch_col != 7'(ec)
            || bus.fetch_row != 10'(er))
          ord_err++;
      end
      step(1);
    end
    chk1("pos_track", pos_err, 0);
    chk1("de_count", de_n, HV * VV);
    chk1("hs_count", hs_n, HS * VT);
    chk1("vs_count", vs_n, VS * HT);
    chk1("fetch_count", fe_n, (HV / 8) * VV);
    chk1("fs_count", fs_n, 1);
    chk1("fetch_order", ord_err, 0);
    chk1("hs_first", hs_first, HV + HF + PD);
    chk1("vs_first", vs_first, (VV + VF) * HT + PD);
    chk1("de_first", de_first, PD);
    if (IRQ) chk1("irq_seen", irq_hi > 0 ? 1 : 0, 1);
    else chk1("irq_tied", irq_hi, 0);

    chk1("irq_sticky", int'(bus.frame_irq), int'(IRQ));
    bus.irq_ack = 1'b1;
    step(1);
    bus.irq_ack = 1'b0;
    chk1("irq_ack_clr", int'(bus.frame_irq), 0);
    go_hv(3, HT - 1, VV - 1);
    chk1("irq_before", int'(bus.frame_irq), 0);
    step(1);
    chk1("irq_rise", int'(bus.frame_irq), int'(IRQ));

    go_hv(4, 40, VV - 1);
    bus.irq_ack = 1'b1;
    step(1);
    chk1("irq_ack2_clr", int'(bus.frame_irq), 0);
    go_hv(4, 0, VV);
    chk1("irq_set_wins", int'(bus.frame_irq), int'(IRQ));
    bus.irq_ack = 1'b0;
    step(1);
    chk1("irq_hold", int'(bus.frame_irq), int'(IRQ));

    go_hv(5, 40, 3);
    chk("pre_rst", pk(tbl[9]));
    #2;
    n_rst = 1'b0;
    #1;
    chk("mid_rst", pk('{0, 0, 0, 0, 0, 0, 0, 0, 0}));
    chk1("mid_rst_irq", int'(bus.frame_irq), 0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    k = 0;
    chk("rel_0", pk('{0, 0, 0, 0, 0, 0, 0, 0, 0}));
    go(3);
    chk("rel_3", pk('{3, 0, 1, 0, 0, 0, 0, 0, 0}));
    go(38);
    chk("rel_38", pk('{38, 0, 0, 1, 0, 0, 3, 0, 0}));
    go(40);
    t = '{40, 0, 0, 1, 0, 1, 0, 1, 0};
    chk("rel_40", pk(t));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
